controle_tentativas: RTL and testbench



---
 rtl/controle_pkg.sv | 16 +
 rtl/controle_tentativas_detector_borda.sv | 26 ++
 rtl/controle_tentativas.sv | 152 +++++++++++++++
 tb/tb_controle_tentativas.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/controle_pkg.sv
// Shared types and constants for the attempt-limiting controller in front of the Estados lock.
package controle_pkg;

    typedef enum logic {
        LIVRE     = 1'b0,
        BLOQUEADO = 1'b1
    } estado_t;

    localparam logic [1:0] ESTADO_ABERTO = 2'b11;

    // Width of the error counter; it must be able to hold MAX_TENTATIVAS itself.
    function automatic int largura_tentativas(input int max_tentativas);
        return (max_tentativas < 1) ? 1 : $clog2(max_tentativas + 1);
    endfunction

endpackage

// File: rtl/controle_tentativas_detector_borda.sv
// Rising-edge detector: registered history of the input, combinational edge flag.
module detector_borda (
    input  logic clk,
    input  logic reset,
    input  logic sinal,
    output logic borda
);

    logic hist_q;
    logic hist_d;

    always_comb begin
        hist_d = sinal;
        borda  = sinal & ~hist_q;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_q <= 1'b0;
        end else begin
            hist_q <= hist_d;
        end
    end

endmodule

// File: rtl/controle_tentativas.sv
// Attempt limiter for the Estados lock: insertion pulses, error counting, timed lockout.
// Optional inactivity timeout is compiled in with CONTROLE_INATIVIDADE_EN.
module controle_tentativas
    import controle_pkg::*;
#(
    parameter int MAX_TENTATIVAS = 3,
    parameter int TEMPO_BLOQUEIO = 50,
    parameter int TEMPO_INATIVO  = 200
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic [3:0]                                   numero,
    input  logic                                         insere,
    input  logic                                         ledErro,
    input  logic [1:0]                                   displayEstado,
    output logic [3:0]                                   numero_out,
    output logic                                         insere_out,
    output logic                                         fechadura_reset,
    output logic                                         bloqueado,
    output logic [largura_tentativas(MAX_TENTATIVAS)-1:0] tentativas
);

    localparam int TW = largura_tentativas(MAX_TENTATIVAS);
    localparam int BW = $clog2(TEMPO_BLOQUEIO + 1);
    localparam logic [TW-1:0] MAX_T = TW'(MAX_TENTATIVAS);
    localparam logic [BW-1:0] CARGA = BW'(TEMPO_BLOQUEIO - 1);

    estado_t         estado_q, estado_d;
    logic [BW-1:0]   timer_q, timer_d;
    logic [TW-1:0]   tent_q, tent_d;
    logic [3:0]      numero_out_q, numero_out_d;
    logic            insere_out_q, insere_out_d;
    logic            bloqueado_q, bloqueado_d;
    logic            fechadura_reset_q, fechadura_reset_d;
    logic            borda_insere, borda_erro;
    logic            pulso_inativo;

    detector_borda u_borda_insere (
        .clk   (clk),
        .reset (reset),
        .sinal (insere),
        .borda (borda_insere)
    );

    detector_borda u_borda_erro (
        .clk   (clk),
        .reset (reset),
        .sinal (ledErro),
        .borda (borda_erro)
    );

    // NOTE: every signal gets a default first so no path through the block infers a latch.
    always_comb begin
        estado_d     = estado_q;
        timer_d      = timer_q;
        tent_d       = tent_q;
        numero_out_d = numero_out_q;
        insere_out_d = 1'b0;

        case (estado_q)
            LIVRE: begin
                if (borda_erro) begin
                    if (tent_q != MAX_T) begin
                        tent_d = tent_q + 1'b1;
                    end
                    if (tent_d == MAX_T) begin
                        estado_d = BLOQUEADO;
                        timer_d  = CARGA;
                    end
                end else if (displayEstado == ESTADO_ABERTO) begin
                    tent_d = '0;
                end
                // An insertion coinciding with the lockout entry is dropped.
                if (borda_insere && (estado_d == LIVRE)) begin
                    insere_out_d = 1'b1;
                    numero_out_d = numero;
                end
            end
            BLOQUEADO: begin
                if (timer_q == '0) begin
                    estado_d = LIVRE;
                    tent_d   = '0;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: estado_d = LIVRE;
        endcase

        bloqueado_d       = (estado_d == BLOQUEADO);
        fechadura_reset_d = bloqueado_d | pulso_inativo;
    end

`ifdef CONTROLE_INATIVIDADE_EN
    localparam int IW = $clog2(TEMPO_INATIVO + 1);

    logic [IW-1:0] inat_q, inat_d;

    always_comb begin
        inat_d        = inat_q;
        pulso_inativo = 1'b0;
        if ((estado_q == BLOQUEADO) || (estado_d == BLOQUEADO) || insere_out_d) begin
            inat_d = '0;
        end else if (displayEstado != 2'b00) begin
            if (inat_q == IW'(TEMPO_INATIVO - 1)) begin
                pulso_inativo = 1'b1;
                inat_d        = '0;
            end else begin
                inat_d = inat_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inat_q <= '0;
        end else begin
            inat_q <= inat_d;
        end
    end
`else
    localparam int tempo_inativo_unused = TEMPO_INATIVO;
    assign pulso_inativo = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q          <= LIVRE;
            timer_q           <= '0;
            tent_q            <= '0;
            numero_out_q      <= '0;
            insere_out_q      <= 1'b0;
            bloqueado_q       <= 1'b0;
            fechadura_reset_q <= 1'b0;
        end else begin
            estado_q          <= estado_d;
            timer_q           <= timer_d;
            tent_q            <= tent_d;
            numero_out_q      <= numero_out_d;
            insere_out_q      <= insere_out_d;
            bloqueado_q       <= bloqueado_d;
            fechadura_reset_q <= fechadura_reset_d;
        end
    end

    assign numero_out      = numero_out_q;
    assign insere_out      = insere_out_q;
    assign bloqueado       = bloqueado_q;
    assign fechadura_reset = fechadura_reset_q;
    assign tentativas      = tent_q;

endmodule

// File: tb/tb_controle_tentativas.sv
// Bench for controle_tentativas: directed plan scenarios plus random stimulus against a cycle model.
module tb_controle_tentativas;

    localparam int MAX   = 3;
    localparam int TEMPO = 8;
    localparam int TW    = $clog2(MAX + 1);

    logic          clk;
    logic          reset;
    logic [3:0]    numero;
    logic          insere;
    logic          ledErro;
    logic [1:0]    displayEstado;
    logic [3:0]    numero_out;
    logic          insere_out;
    logic          fechadura_reset;
    logic          bloqueado;
    logic [TW-1:0] tentativas;

    int n_cmp = 0;
    int n_err = 0;
    int pulsos = 0;

    controle_tentativas #(
        .MAX_TENTATIVAS (MAX),
        .TEMPO_BLOQUEIO (TEMPO),
        .TEMPO_INATIVO  (200)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .numero          (numero),
        .insere          (insere),
        .ledErro         (ledErro),
        .displayEstado   (displayEstado),
        .numero_out      (numero_out),
        .insere_out      (insere_out),
        .fechadura_reset (fechadura_reset),
        .bloqueado       (bloqueado),
        .tentativas      (tentativas)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: cycles of lockout remaining, error count, last input samples, last pulse, held digit.
    typedef struct {
        int lock_left;
        int count;
        bit prev_ins;
        bit prev_err;
        bit pulse;
        int num;
    } modelo_t;

    modelo_t m;

    function automatic modelo_t proximo(modelo_t a, bit ins, bit err, logic [1:0] disp, logic [3:0] num);
        modelo_t b;
        bit e_ins;
        bit e_err;
        b = a;
        e_ins = ins && !a.prev_ins;
        e_err = err && !a.prev_err;
        b.pulse = 0;
        b.prev_ins = ins;
        b.prev_err = err;
        if (a.lock_left > 0) begin
            b.lock_left = a.lock_left - 1;
            if (b.lock_left == 0) b.count = 0;
        end else begin
            if (e_err) begin
                b.count = a.count + 1;
                if (b.count >= MAX) begin
                    b.count = MAX;
                    b.lock_left = TEMPO;
                end
            end else if (disp == 2'b11) begin
                b.count = 0;
            end
            if (e_ins && b.lock_left == 0) begin
                b.pulse = 1;
                b.num = int'(num);
            end
        end
        return b;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) m <= '{0, 0, 0, 0, 0, 0};
        else       m <= proximo(m, insere, ledErro, displayEstado, numero);
    end

    always @(posedge clk) begin
        if (!reset && insere_out) pulsos <= pulsos + 1;
    end

    task automatic check(input string nome, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nome, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("tentativas", 32'(tentativas), m.count);
        check("bloqueado", 32'(bloqueado), (m.lock_left > 0) ? 1 : 0);
        check("fechadura_reset", 32'(fechadura_reset), (m.lock_left > 0) ? 1 : 0);
        check("insere_out", 32'(insere_out), 32'(m.pulse));
        check("numero_out", 32'(numero_out), m.num);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic erro_pulso(input int esperado);
        ledErro = 1'b1;
        tick(1);
        ledErro = 1'b0;
        check("erro_tentativas", 32'(tentativas), esperado);
    endtask

    initial begin
        int p0;
        int blk;
        reset = 1'b1;
        numero = 4'd0;
        insere = 1'b0;
        ledErro = 1'b0;
        displayEstado = 2'b00;

        tick(2);
        check("rst_numero_out", 32'(numero_out), 0);
        check("rst_insere_out", 32'(insere_out), 0);
        check("rst_fechadura", 32'(fechadura_reset), 0);
        check("rst_bloqueado", 32'(bloqueado), 0);
        check("rst_tentativas", 32'(tentativas), 0);
        reset = 1'b0;
        tick(2);

        // Held button gives exactly one pulse.
        p0 = pulsos;
        numero = 4'd5;
        insere = 1'b1;
        tick(5);
        insere = 1'b0;
        tick(3);
        check("held_pulse_count", pulsos - p0, 1);
        check("held_numero_out", 32'(numero_out), 5);

        // Three errors, lockout length, insertion discarded during lockout.
        erro_pulso(1);
        tick(2);
        erro_pulso(2);
        tick(2);
        erro_pulso(3);
        blk = 0;
        for (int i = 0; i < 20; i++) begin
            if (bloqueado) blk++;
            if (i == 2) begin
                numero = 4'd9;
                insere = 1'b1;
            end
            if (i == 5) insere = 1'b0;
            tick(1);
        end
        check("lock_cycles", blk, TEMPO);
        check("lock_end_bloqueado", 32'(bloqueado), 0);
        check("lock_end_tentativas", 32'(tentativas), 0);
        check("lock_no_pulse", pulsos - p0, 1);
        check("lock_numero_kept", 32'(numero_out), 5);

        // Open indication clears the count.
        erro_pulso(1);
        tick(2);
        erro_pulso(2);
        tick(2);
        displayEstado = 2'b11;
        tick(1);
        displayEstado = 2'b00;
        check("open_clears", 32'(tentativas), 0);
        tick(1);
        erro_pulso(1);
        check("open_no_lock", 32'(bloqueado), 0);
        displayEstado = 2'b11;
        tick(1);
        displayEstado = 2'b00;
        tick(1);

        // Reset in the middle of a lockout.
        erro_pulso(1);
        tick(2);
        erro_pulso(2);
        tick(2);
        erro_pulso(3);
        tick(4);
        check("pre_reset_bloqueado", 32'(bloqueado), 1);
        #1 reset = 1'b1;
        #1;
        check("async_rst_bloqueado", 32'(bloqueado), 0);
        check("async_rst_tentativas", 32'(tentativas), 0);
        tick(1);
        reset = 1'b0;
        tick(1);
        numero = 4'd3;
        insere = 1'b1;
        tick(1);
        insere = 1'b0;
        check("post_rst_pulse", 32'(insere_out), 1);
        check("post_rst_numero", 32'(numero_out), 3);
        tick(2);

        // Random traffic, checked every cycle by the compare process.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) insere = ~insere;
            ledErro = ($urandom_range(0, 15) == 0);
            numero = 4'($urandom_range(0, 15));
            displayEstado = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            tick(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
